// File: rtl/cmos_capture_raw_win.sv
// cmos_capture_raw_win: RAW/gray DVP capture front-end on cmos_pclk.
// Syncs pins, waits for the sensor to settle, crops, decimates, checks lines, measures fps.
//
// Ports:
//   cmos_pclk, rst_n               pixel clock (rising edge), async active-low reset
//   cmos_vsync/href/data           sensor pins
//   err_clr                        clears line_len_err
//   out_vsync/href/data/sof        gated, cropped DVP-style output stream
//   vsync_end                      pulse on each synced vsync falling edge
//   pixel_cnt, line_cnt            stage-2 pixel/line indices
//   line_len_err                   sticky line-length mismatch flag
//   fps_rate                       input frames per second, updated every 2 s
module cmos_capture_raw_win #(
   parameter int DATA_W        = 8,
   parameter int CNT_W         = 12,
   parameter int FRAME_WAITCNT = 3,
   parameter int CLK_FREQ      = 74_250_000,
   parameter int H_START       = 0,
   parameter int H_END         = 1279,
   parameter int V_START       = 3,
   parameter int V_END         = 722,
   parameter int FRAME_DECIM   = 1,
   parameter int EXP_LINE_LEN  = 1280
) (
   input  logic              cmos_pclk,
   input  logic              rst_n,
   input  logic              cmos_vsync,
   input  logic              cmos_href,
   input  logic [DATA_W-1:0] cmos_data,
   input  logic              err_clr,
   output logic              out_vsync,
   output logic              out_href,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sof,
   output logic              vsync_end,
   output logic [CNT_W-1:0]  pixel_cnt,
   output logic [CNT_W-1:0]  line_cnt,
   output logic              line_len_err,
   output logic [7:0]        fps_rate
);

   localparam logic [3:0]       WAIT_N   = 4'(FRAME_WAITCNT);
   localparam logic [3:0]       DEC_LAST = 4'(FRAME_DECIM - 1);
   localparam logic [CNT_W-1:0] H_S      = CNT_W'(H_START);
   localparam logic [CNT_W-1:0] V_S      = CNT_W'(V_START);
   localparam logic [CNT_W-1:0] H_SPAN   = CNT_W'(H_END - H_START);
   localparam logic [CNT_W-1:0] V_SPAN   = CNT_W'(V_END - V_START);
   localparam logic [CNT_W:0]   EXP_LEN  = (CNT_W+1)'(EXP_LINE_LEN);
   localparam bit               LEN_CHK  = (EXP_LINE_LEN != 0);
   localparam logic [27:0]      FPS_LAST = 28'(2 * CLK_FREQ - 1);

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t            state;
   logic [3:0]        wait_cnt;
   logic [1:0]        vs_r;
   logic [1:0]        hs_r;
   logic [DATA_W-1:0] d_r0;
   logic [DATA_W-1:0] d_r1;
   logic [3:0]        dec_cnt;
   logic              frame_en;
   logic [27:0]       fps_tmr;
   logic [8:0]        fps_cnt;

   logic              vs1;
   logic              hs1;
   logic              vs2;
   logic              hs2;
   logic [DATA_W-1:0] d2;
   logic              run;
   logic              vs_rise;
   logic              line_end;
   logic              len_bad;
   logic [CNT_W-1:0]  h_off;
   logic [CNT_W-1:0]  v_off;
   logic              win;
   logic              href_nxt;
   logic              fps_last;

   // Stage-1 values are what stage 2 will hold next cycle; the counters
   // and frame_en are computed from them so they line up with stage 2.
   assign vs1       = vs_r[0];
   assign hs1       = hs_r[0] & vs_r[0];
   assign vs2       = vs_r[1];
   assign hs2       = hs_r[1] & vs_r[1];
   assign d2        = d_r1;
   assign vsync_end = vs_r[1] & ~vs_r[0];
   assign vs_rise   = vs_r[0] & ~vs_r[1];
   assign run       = (state == S_RUN);

   // A line ends when href drops while vsync stays high; a vsync drop
   // cuts the line short and is not treated as a line end.
   assign line_end  = hs2 & ~hs1 & vs1;
   assign len_bad   = ((CNT_W+1)'(pixel_cnt) + (CNT_W+1)'(1)) != EXP_LEN;

   // Unsigned offset trick: below-start values wrap past the span.
   assign h_off     = pixel_cnt - H_S;
   assign v_off     = line_cnt - V_S;
   assign win       = (h_off <= H_SPAN) && (v_off <= V_SPAN);
   assign href_nxt  = run & frame_en & hs2 & win;
   assign fps_last  = (fps_tmr == FPS_LAST);

   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_r <= '0;
         hs_r <= '0;
         d_r0 <= '0;
         d_r1 <= '0;
      end else begin
         vs_r <= {vs_r[0], cmos_vsync};
         hs_r <= {hs_r[0], cmos_href};
         d_r0 <= cmos_data;
         d_r1 <= d_r0;
      end
   end

   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_cnt <= '0;
         line_cnt  <= '0;
      end else begin
         if (!hs1)
            pixel_cnt <= '0;
         else if (hs2)
            pixel_cnt <= pixel_cnt + CNT_W'(1);
         else
            pixel_cnt <= '0;

         if (!vs1)
            line_cnt <= '0;
         else if (hs2 && !hs1)
            line_cnt <= line_cnt + CNT_W'(1);
      end
   end

   // The ARM state holds off until a frame boundary so output always
   // starts on a complete frame.
   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_WAIT;
         wait_cnt <= '0;
      end else begin
         unique case (state)
            S_WAIT: begin
               if (wait_cnt == WAIT_N)
                  state <= S_ARM;
               else if (vsync_end)
                  wait_cnt <= wait_cnt + 4'd1;
            end
            S_ARM: begin
               if (vsync_end)
                  state <= S_RUN;
            end
            S_RUN: begin
               state <= S_RUN;
            end
            default: begin
               state <= S_WAIT;
            end
         endcase
      end
   end

   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         dec_cnt  <= '0;
         frame_en <= 1'b0;
      end else if (run && vs_rise) begin
         frame_en <= (dec_cnt == 4'd0);
         if (dec_cnt == DEC_LAST)
            dec_cnt <= '0;
         else
            dec_cnt <= dec_cnt + 4'd1;
      end
   end

   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         out_vsync <= 1'b0;
         out_href  <= 1'b0;
         out_data  <= '0;
         out_sof   <= 1'b0;
      end else begin
         out_vsync <= run & frame_en & vs2;
         out_href  <= href_nxt;
         out_data  <= href_nxt ? d2 : '0;
         out_sof   <= href_nxt && (pixel_cnt == H_S) && (line_cnt == V_S);
      end
   end

   // Set has priority over clear so a coincident error is never lost.
   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n)
         line_len_err <= 1'b0;
      else if (LEN_CHK && run && line_end && len_bad)
         line_len_err <= 1'b1;
      else if (err_clr)
         line_len_err <= 1'b0;
   end

   // fps_cnt holds frames per two seconds; halving gives frames/s.
   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         fps_tmr  <= '0;
         fps_cnt  <= '0;
         fps_rate <= '0;
      end else if (fps_last) begin
         fps_tmr  <= '0;
         fps_cnt  <= '0;
         fps_rate <= fps_cnt[8:1];
      end else begin
         fps_tmr <= fps_tmr + 28'd1;
         if (vsync_end && fps_cnt != 9'h1FF)
            fps_cnt <= fps_cnt + 9'd1;
      end
   end

endmodule

// File: tb/tb_cmos_capture_raw_win.sv
// tb_cmos_capture_raw_win: directed bench for cmos_capture_raw_win.
// Two instances share the pins: A crops/checks lines, B decimates by 3.
module tb_cmos_capture_raw_win;

   logic       cmos_pclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmos_vsync = 1'b0;
   logic       cmos_href = 1'b0;
   logic [7:0] cmos_data = '0;
   logic       err_clr = 1'b0;

   logic        a_out_vsync, a_out_href, a_out_sof, a_vsync_end;
   logic [7:0]  a_out_data, a_fps_rate;
   logic [11:0] a_pixel_cnt, a_line_cnt;
   logic        a_line_len_err;

   logic        b_out_vsync, b_out_href, b_out_sof, b_vsync_end;
   logic [7:0]  b_out_data, b_fps_rate;
   logic [11:0] b_pixel_cnt, b_line_cnt;
   logic        b_line_len_err;

   int n_vec = 0;
   int n_err = 0;
   int ncyc  = 0;
   int a_vs, a_hr, a_sof, a_sof_at, a_bad, a_ve;
   int b_vs, b_hr, b_sof, b_bad;
   int pin_at;
   int pc_snap, lc_snap;

   always #5 cmos_pclk = ~cmos_pclk;

   cmos_capture_raw_win #(
      .DATA_W(8), .CNT_W(12), .FRAME_WAITCNT(2), .CLK_FREQ(100),
      .H_START(2), .H_END(5), .V_START(1), .V_END(2),
      .FRAME_DECIM(1), .EXP_LINE_LEN(8)
   ) u_a (
      .cmos_pclk(cmos_pclk), .rst_n(rst_n),
      .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
      .cmos_data(cmos_data), .err_clr(err_clr),
      .out_vsync(a_out_vsync), .out_href(a_out_href),
      .out_data(a_out_data), .out_sof(a_out_sof),
      .vsync_end(a_vsync_end), .pixel_cnt(a_pixel_cnt),
      .line_cnt(a_line_cnt), .line_len_err(a_line_len_err),
      .fps_rate(a_fps_rate)
   );

   cmos_capture_raw_win #(
      .DATA_W(8), .CNT_W(12), .FRAME_WAITCNT(0), .CLK_FREQ(100),
      .H_START(0), .H_END(7), .V_START(0), .V_END(3),
      .FRAME_DECIM(3), .EXP_LINE_LEN(0)
   ) u_b (
      .cmos_pclk(cmos_pclk), .rst_n(rst_n),
      .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
      .cmos_data(cmos_data), .err_clr(err_clr),
      .out_vsync(b_out_vsync), .out_href(b_out_href),
      .out_data(b_out_data), .out_sof(b_out_sof),
      .vsync_end(b_vsync_end), .pixel_cnt(b_pixel_cnt),
      .line_cnt(b_line_cnt), .line_len_err(b_line_len_err),
      .fps_rate(b_fps_rate)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic clr_acc();
      a_vs = 0; a_hr = 0; a_sof = 0; a_sof_at = 0; a_bad = 0;
      b_vs = 0; b_hr = 0; b_sof = 0; b_bad = 0;
      pin_at = 0;
   endtask

   // Sample outputs just after an edge, then drive the next pin values.
   task automatic cyc(input logic v, input logic h,
                      input logic [7:0] d, input logic clr);
      @(posedge cmos_pclk);
      #1;
      ncyc++;
      if (a_out_vsync) a_vs++;
      if (a_out_href) begin
         if (a_out_data != 8'(2 + a_hr % 4)) a_bad++;
         a_hr++;
      end else if (a_out_data != 8'd0) a_bad++;
      if (a_out_sof) begin
         a_sof++;
         a_sof_at = ncyc;
      end
      if (a_vsync_end) a_ve++;
      if (b_out_vsync) b_vs++;
      if (b_out_href) begin
         if (b_out_data != 8'(b_hr % 8)) b_bad++;
         b_hr++;
      end else if (b_out_data != 8'd0) b_bad++;
      if (b_out_sof) b_sof++;
      cmos_vsync = v;
      cmos_href  = h;
      cmos_data  = d;
      err_clr    = clr;
   endtask

   // 4 lines x 8 px (one 7-px line if short_ln in 0..3); vsync high 50 cycles.
   task automatic frame(input int short_ln, input logic clr_same);
      int len;
      clr_acc();
      repeat (2) cyc(1'b1, 1'b0, 8'd0, 1'b0);
      for (int ln = 0; ln < 4; ln++) begin
         len = (ln == short_ln) ? 7 : 8;
         for (int p = 0; p < len; p++) begin
            cyc(1'b1, 1'b1, 8'(p), 1'b0);
            if (ln == 1 && p == 2) pin_at = ncyc;
            if (ln == 2 && p == 7) begin
               pc_snap = int'(a_pixel_cnt);
               lc_snap = int'(a_line_cnt);
            end
         end
         for (int g = 0; g < 4; g++)
            cyc(1'b1, 1'b0, 8'd0,
                clr_same && ln == short_ln && g == 1);
      end
      repeat (6) cyc(1'b0, 1'b0, 8'd0, 1'b0);
   endtask

   function automatic logic [63:0] a_all();
      return {19'd0, a_out_vsync, a_out_href, a_out_data, a_out_sof,
              a_vsync_end, a_pixel_cnt, a_line_cnt, a_line_len_err,
              a_fps_rate};
   endfunction

   function automatic logic [63:0] b_all();
      return {19'd0, b_out_vsync, b_out_href, b_out_data, b_out_sof,
              b_vsync_end, b_pixel_cnt, b_line_cnt, b_line_len_err,
              b_fps_rate};
   endfunction

   initial begin
      bit bpass;
      repeat (3) @(posedge cmos_pclk);
      #1;
      chk("rst_a", a_all(), 64'd0);
      chk("rst_b", b_all(), 64'd0);
      rst_n = 1'b1;
      repeat (10) cyc(1'b0, 1'b0, 8'd0, 1'b0);

      // A: frames 1-3 settle/arm, 4+ output. B: output frames 2, 5, 8.
      for (int f = 1; f <= 8; f++) begin
         frame(-1, 1'b0);
         bpass = (f == 2 || f == 5 || f == 8);
         chk($sformatf("a_vs_f%0d", f), a_vs, (f >= 4) ? 50 : 0);
         chk($sformatf("a_href_f%0d", f), a_hr, (f >= 4) ? 8 : 0);
         chk($sformatf("a_sof_f%0d", f), a_sof, (f >= 4) ? 1 : 0);
         chk($sformatf("a_data_f%0d", f), a_bad, 0);
         if (f >= 4)
            chk($sformatf("a_sof_lat_f%0d", f), a_sof_at - pin_at, 3);
         chk($sformatf("b_vs_f%0d", f), b_vs, bpass ? 50 : 0);
         chk($sformatf("b_href_f%0d", f), b_hr, bpass ? 32 : 0);
         chk($sformatf("b_sof_f%0d", f), b_sof, bpass ? 1 : 0);
         chk($sformatf("b_data_f%0d", f), b_bad, 0);
         if (f == 4) begin
            chk("pixel_cnt", pc_snap, 5);
            chk("line_cnt", lc_snap, 2);
         end
      end
      chk("a_err_clean", a_line_len_err, 1'b0);

      frame(2, 1'b0);
      chk("a_err_short", a_line_len_err, 1'b1);
      chk("b_err_off", b_line_len_err, 1'b0);
      cyc(1'b0, 1'b0, 8'd0, 1'b1);
      cyc(1'b0, 1'b0, 8'd0, 1'b0);
      chk("a_err_clr", a_line_len_err, 1'b0);
      frame(2, 1'b1);
      chk("a_err_set_wins", a_line_len_err, 1'b1);

      // Reset mid-line while A is emitting pixels.
      repeat (2) cyc(1'b1, 1'b0, 8'd0, 1'b0);
      for (int p = 0; p < 8; p++) cyc(1'b1, 1'b1, 8'(p), 1'b0);
      repeat (4) cyc(1'b1, 1'b0, 8'd0, 1'b0);
      for (int p = 0; p < 7; p++) cyc(1'b1, 1'b1, 8'(p), 1'b0);
      chk("pre_rst_href", a_out_href, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midline_rst_a", a_all(), 64'd0);
      chk("midline_rst_b", b_all(), 64'd0);
      cmos_vsync = 1'b0;
      cmos_href  = 1'b0;
      cmos_data  = '0;
      repeat (3) @(posedge cmos_pclk);
      #2;
      rst_n = 1'b1;
      repeat (5) cyc(1'b0, 1'b0, 8'd0, 1'b0);
      for (int f = 1; f <= 4; f++) begin
         frame(-1, 1'b0);
         chk($sformatf("rewait_vs_f%0d", f), a_vs, (f == 4) ? 50 : 0);
      end

      // FPS: window 200 cycles, vsync period 20 -> 10 frames -> 5 fps.
      @(posedge cmos_pclk);
      #2;
      rst_n = 1'b0;
      #1;
      @(posedge cmos_pclk);
      #2;
      rst_n = 1'b1;
      a_ve = 0;
      for (int k = 1; k <= 400; k++) begin
         cyc(((k - 1) % 20) < 10, 1'b0, 8'd0, 1'b0);
         if (k == 150) chk("fps_before", a_fps_rate, 8'd0);
         if (k == 200) begin
            chk("vsync_end_cnt", a_ve, 10);
            chk("fps_a_w1", a_fps_rate, 8'd5);
            chk("fps_b_w1", b_fps_rate, 8'd5);
         end
         if (k == 400) chk("fps_a_w2", a_fps_rate, 8'd5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
